// File: rtl/wwm_pkg.sv
// Constants and state encoding shared by the projectile engine and the game controller.
package wwm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_FLIGHT = 4'b0010,
    ST_HIT    = 4'b0100,
    ST_MISS   = 4'b1000
  } wwm_state_t;

  localparam logic signed [11:0] X0        = 12'sd200;
  localparam logic signed [11:0] Y0        = 12'sd400;
  localparam logic signed [11:0] TGT_X_MIN = 12'sd650;
  localparam logic signed [11:0] TGT_X_MAX = 12'sd675;
  localparam logic signed [11:0] TGT_Y_MIN = 12'sd470;
  localparam logic signed [11:0] TGT_Y_MAX = 12'sd475;
  localparam logic signed [11:0] BND_X_MIN = 12'sd160;
  localparam logic signed [11:0] BND_X_MAX = 12'sd775;
  localparam logic signed [11:0] BND_Y_MIN = 12'sd50;
  localparam logic signed [11:0] BND_Y_MAX = 12'sd475;

  localparam logic [3:0]        VSCALE            = 4'd2;
  localparam logic signed [9:0] GRAVITY           = 10'sd1;
  localparam logic [9:0]        MAX_TICKS_DEFAULT = 10'd1023;

  // Screen coordinates are unsigned 10b; the internal position may briefly leave that range.
  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v);
    logic [9:0] r;
    if (v < 12'sd0) begin
      r = 10'd0;
    end else if (v > 12'sd1023) begin
      r = 10'd1023;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/wwm_projectile_engine_if.sv
// Fire/animate handshake between the game controller (master) and the projectile engine (slave).
// The wind input exists only when WWM_WIND_EN is defined.
interface wwm_projectile_engine_if;
  logic       tick;
  logic       launch;
  logic       ack;
  logic [3:0] vX;
  logic [3:0] vY;
`ifdef WWM_WIND_EN
  logic [3:0] wind;
`endif
  logic [9:0] proj_x;
  logic [9:0] proj_y;
  logic       busy;
  logic       hit;
  logic       miss;

  modport master (
`ifdef WWM_WIND_EN
    output wind,
`endif
    output tick, launch, ack, vX, vY,
    input  proj_x, proj_y, busy, hit, miss
  );

  modport slave (
`ifdef WWM_WIND_EN
    input  wind,
`endif
    input  tick, launch, ack, vX, vY,
    output proj_x, proj_y, busy, hit, miss
  );
endinterface

// File: rtl/wwm_bounds_check.sv
// Combinational classification of a projectile position against the target box and play field.
module wwm_bounds_check
  import wwm_pkg::*;
(
  input  logic signed [11:0] i_x,
  input  logic signed [11:0] i_y,
  output logic               o_in_target,
  output logic               o_out_of_bounds
);

  assign o_in_target = (i_x >= TGT_X_MIN) && (i_x <= TGT_X_MAX) &&
                       (i_y >= TGT_Y_MIN) && (i_y <= TGT_Y_MAX);

  // Touching a limit already counts as out.
  assign o_out_of_bounds = (i_x >= BND_X_MAX) || (i_x <= BND_X_MIN) ||
                           (i_y >= BND_Y_MAX) || (i_y <= BND_Y_MIN);

endmodule

// File: rtl/wwm_projectile_engine.sv
// Projectile integrator with hit/miss verdict held until acknowledged.
// Optional feature: WWM_WIND_EN adds a latched wind input that nudges vx every 8th tick.
module wwm_projectile_engine
  import wwm_pkg::*;
#(
  parameter logic [9:0] MAX_TICKS = MAX_TICKS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    Reset,
  wwm_projectile_engine_if.slave  bus
);

  wwm_state_t        r_state, w_state_nxt;
  logic signed [11:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic signed [7:0]  r_vx, w_vx_nxt, w_vx_load;
  logic signed [9:0]  r_vy, w_vy_load;
  logic [9:0]         r_tick_cnt;
  logic [9:0]         r_proj_x, r_proj_y;
  logic               r_busy, r_hit, r_miss;
  logic               w_busy_nxt, w_hit_nxt, w_miss_nxt;
  logic               w_in_target, w_out_of_bounds, w_timeout, w_terminal;
  logic               w_load, w_step;

  wwm_bounds_check u_bounds (
    .i_x             (r_x),
    .i_y             (r_y),
    .o_in_target     (w_in_target),
    .o_out_of_bounds (w_out_of_bounds)
  );

  assign w_timeout  = (r_tick_cnt == MAX_TICKS);
  assign w_terminal = w_in_target || w_out_of_bounds || w_timeout;
  assign w_load     = bus.launch && ((r_state == ST_IDLE) || (r_state == ST_HIT) || (r_state == ST_MISS));
  assign w_step     = (r_state == ST_FLIGHT) && bus.tick && !w_terminal;
  assign w_vx_load  = {4'b0000, bus.vX} * {4'b0000, VSCALE};
  assign w_vy_load  = {6'b000000, bus.vY} * {6'b000000, VSCALE};

`ifdef WWM_WIND_EN
  logic signed [3:0] r_wind;
  logic signed [8:0] w_vx_sum;

  assign w_vx_sum = {r_vx[7], r_vx} + {{5{r_wind[3]}}, r_wind};

  // Wind is sampled once per flight.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_wind <= 4'sd0;
    end else if (w_load) begin
      r_wind <= bus.wind;
    end
  end

  // Gust applied on every 8th tick, saturated to the vx range.
  always_comb begin
    if (r_tick_cnt[2:0] != 3'd7) begin
      w_vx_nxt = r_vx;
    end else if (w_vx_sum > 9'sd127) begin
      w_vx_nxt = 8'sd127;
    end else if (w_vx_sum < -9'sd128) begin
      w_vx_nxt = -8'sd128;
    end else begin
      w_vx_nxt = w_vx_sum[7:0];
    end
  end
`else
  assign w_vx_nxt = r_vx;
`endif

  // State and verdict register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_hit   <= w_hit_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  // Next state; a hit takes priority over any miss condition, launch over ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.launch) w_state_nxt = ST_FLIGHT;
        else            w_state_nxt = ST_IDLE;
      end
      ST_FLIGHT: begin
        if (w_in_target)                       w_state_nxt = ST_HIT;
        else if (w_out_of_bounds || w_timeout) w_state_nxt = ST_MISS;
        else                                   w_state_nxt = ST_FLIGHT;
      end
      ST_HIT, ST_MISS: begin
        if (bus.launch)   w_state_nxt = ST_FLIGHT;
        else if (bus.ack) w_state_nxt = ST_IDLE;
        else              w_state_nxt = r_state;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state so flags change together with the state flops.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_hit_nxt  = 1'b0;
    w_miss_nxt = 1'b0;
    case (w_state_nxt)
      ST_FLIGHT: w_busy_nxt = 1'b1;
      ST_HIT:    w_hit_nxt  = 1'b1;
      ST_MISS:   w_miss_nxt = 1'b1;
      default:   w_busy_nxt = 1'b0;
    endcase
  end

  always_comb begin
    if (w_load) begin
      w_x_nxt = X0;
      w_y_nxt = Y0;
    end else if (w_step) begin
      w_x_nxt = r_x + {{4{r_vx[7]}}, r_vx};
      w_y_nxt = r_y - {{2{r_vy[9]}}, r_vy};
    end else begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
    end
  end

  // Motion state; coordinates for the renderer are clamped as they are registered.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_x        <= X0;
      r_y        <= Y0;
      r_vx       <= 8'sd0;
      r_vy       <= 10'sd0;
      r_tick_cnt <= 10'd0;
      r_proj_x   <= clamp_coord(X0);
      r_proj_y   <= clamp_coord(Y0);
    end else begin
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_proj_x <= clamp_coord(w_x_nxt);
      r_proj_y <= clamp_coord(w_y_nxt);
      if (w_load) begin
        r_vx       <= w_vx_load;
        r_vy       <= w_vy_load;
        r_tick_cnt <= 10'd0;
      end else if (w_step) begin
        r_vx <= w_vx_nxt;
        r_vy <= r_vy - GRAVITY;
        if (r_tick_cnt != MAX_TICKS) r_tick_cnt <= r_tick_cnt + 10'd1;
      end
    end
  end

  assign bus.proj_x = r_proj_x;
  assign bus.proj_y = r_proj_y;
  assign bus.busy   = r_busy;
  assign bus.hit    = r_hit;
  assign bus.miss   = r_miss;

endmodule

// File: tb/tb_wwm_projectile_engine.sv
// Scoreboard bench: stimulus pushes expected observations, a monitor pops one per output change.
module tb_wwm_projectile_engine;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       busy;
    logic       hit;
    logic       miss;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wwm_projectile_engine_if bus1 ();
  wwm_projectile_engine_if bus2 ();

  wwm_projectile_engine dut1 (.clk(clk), .Reset(rst), .bus(bus1));
  wwm_projectile_engine #(.MAX_TICKS(10'd4)) dut2 (.clk(clk), .Reset(rst), .bus(bus2));

  obs_t  q1[$], q2[$];
  string n1[$], n2[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  int    m_vx, m_vy, m_n, m_x, m_y, m_wind;

  obs_t cur1, cur2;
  assign cur1 = {bus1.proj_x, bus1.proj_y, bus1.busy, bus1.hit, bus1.miss};
  assign cur2 = {bus2.proj_x, bus2.proj_y, bus2.busy, bus2.hit, bus2.miss};

  function automatic string fmt(input obs_t o);
    return $sformatf("x=%0d y=%0d busy=%0b hit=%0b miss=%0b", o.x, o.y, o.busy, o.hit, o.miss);
  endfunction

  task automatic push(input int d, input string nm, input int x, input int y,
                      input bit b, input bit h, input bit m);
    obs_t e;
    e.x = 10'(x); e.y = 10'(y); e.busy = b; e.hit = h; e.miss = m;
    if (d == 1) begin q1.push_back(e); n1.push_back(nm); end
    else        begin q2.push_back(e); n2.push_back(nm); end
  endtask

  task automatic check(input int d, input obs_t got);
    obs_t  e;
    string nm;
    checks++;
    if ((d == 1 && q1.size() == 0) || (d == 2 && q2.size() == 0)) begin
      errors++;
      $display("FAIL dut%0d_unexpected_change got %s required no change", d, fmt(got));
    end else begin
      if (d == 1) begin e = q1.pop_front(); nm = n1.pop_front(); end
      else        begin e = q2.pop_front(); nm = n2.pop_front(); end
      if (got !== e) begin
        errors++;
        $display("FAIL %s got %s required %s", nm, fmt(got), fmt(e));
      end
    end
  endtask

  initial begin : monitor
    obs_t p1, p2;
    wait (mon_en);
    @(negedge clk);
    check(1, cur1); p1 = cur1;
    check(2, cur2); p2 = cur2;
    forever begin
      @(negedge clk);
      if (cur1 !== p1) begin check(1, cur1); p1 = cur1; end
      if (cur2 !== p2) begin check(2, cur2); p2 = cur2; end
    end
  end

  task automatic pulse(input int d, input bit t, input bit l, input bit a);
    @(negedge clk);
    if (d == 1) begin bus1.tick = t; bus1.launch = l; bus1.ack = a; end
    else        begin bus2.tick = t; bus2.launch = l; bus2.ack = a; end
    @(negedge clk);
    bus1.tick = 1'b0; bus1.launch = 1'b0; bus1.ack = 1'b0;
    bus2.tick = 1'b0; bus2.launch = 1'b0; bus2.ack = 1'b0;
  endtask

  task automatic launch(input int d, input string nm, input int vx, input int vy, input bit with_ack);
    m_vx = vx; m_vy = vy; m_n = 0; m_x = 200; m_y = 400;
    if (d == 1) begin bus1.vX = 4'(vx); bus1.vY = 4'(vy); end
    else        begin bus2.vX = 4'(vx); bus2.vY = 4'(vy); end
    push(d, nm, 200, 400, 1'b1, 1'b0, 1'b0);
    pulse(d, 1'b0, 1'b1, with_ack);
  endtask

  // verdict: 0 still flying, 1 hit, 2 miss after this tick's position
  task automatic step(input int d, input string nm, input int verdict);
    int ex, ey;
    m_n++;
    ex = 200 + 2 * m_vx * m_n;
`ifdef WWM_WIND_EN
    for (int k = 1; k <= m_n; k++) ex += m_wind * ((k - 1) / 8);
`endif
    ey = 400 - 2 * m_vy * m_n + (m_n * (m_n - 1)) / 2;
    if (ex != m_x || ey != m_y) push(d, $sformatf("%s%0d", nm, m_n), ex, ey, 1'b1, 1'b0, 1'b0);
    m_x = ex; m_y = ey;
    pulse(d, 1'b1, 1'b0, 1'b0);
    if (verdict == 1) push(d, {nm, "_hit"}, ex, ey, 1'b0, 1'b1, 1'b0);
    if (verdict == 2) push(d, {nm, "_miss"}, ex, ey, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m_wind = 0;
    bus1.tick = 1'b0; bus1.launch = 1'b0; bus1.ack = 1'b0; bus1.vX = 4'd0; bus1.vY = 4'd0;
    bus2.tick = 1'b0; bus2.launch = 1'b0; bus2.ack = 1'b0; bus2.vX = 4'd0; bus2.vY = 4'd0;
`ifdef WWM_WIND_EN
    bus1.wind = 4'd0; bus2.wind = 4'd0;
`endif
    push(1, "reset_dut1", 200, 400, 1'b0, 1'b0, 1'b0);
    push(2, "reset_dut2", 200, 400, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (3) @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    launch(1, "t2_launch", 2, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1, "t2_tick", 0);
    push(1, "t1_reset_midflight", 200, 400, 1'b0, 1'b0, 1'b0);
    do_reset();

    launch(1, "t3_launch", 15, 1, 1'b0);
    for (int i = 1; i <= 15; i++) step(1, "t3_tick", (i == 15) ? 1 : 0);
    push(1, "t3_ack", 650, 475, 1'b0, 1'b0, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    launch(1, "t4_launch", 0, 0, 1'b0);
    for (int i = 1; i <= 13; i++) step(1, "t4_tick", (i == 13) ? 2 : 0);
    push(1, "t4_ack", 200, 478, 1'b0, 1'b0, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    launch(1, "t4_relaunch", 0, 0, 1'b0);
    for (int i = 1; i <= 13; i++) step(1, "t4b_tick", (i == 13) ? 2 : 0);
    launch(1, "t4_ack_and_launch", 2, 0, 1'b1);

    step(1, "t5_tick", 0);
    bus1.vX = 4'd15; bus1.vY = 4'd5;
    pulse(1, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    step(1, "t5_after_ignored_launch", 0);
    push(1, "t5_reset", 200, 400, 1'b0, 1'b0, 1'b0);
    do_reset();

    launch(2, "t5_timeout_launch", 1, 8, 1'b0);
    for (int i = 1; i <= 4; i++) step(2, "t5_timeout_tick", (i == 4) ? 2 : 0);

`ifdef WWM_WIND_EN
    m_wind = -2;
    bus1.wind = 4'b1110;
`endif
    launch(1, "t6_launch", 4, 0, 1'b0);
    for (int i = 1; i <= 10; i++) step(1, "t6_tick", 0);

    repeat (4) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d outstanding required 0", q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
